// File: rtl/duck_round_ctrl.sv
// Round sequencer for the duck sprite datapath: drives the duck-block state bus and
// keeps the per-duck shot budget, hit/score tally and round progression.
module duck_round_ctrl #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int PASS_HITS       = 6,
    parameter int SPAWN_FRAMES    = 2,
    parameter int AWAY_FRAMES     = 60,
    parameter int END_FRAMES      = 120,
    parameter int FLY_TIMEOUT     = 600,
    parameter int POINTS          = 500
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        trigger,
    input  logic        hit,
    input  logic        bird_shot,
    input  logic        flew_away,
    input  logic        duck_ded_done,
    output logic [2:0]  state,
    output logic        new_round,
    output logic        shot,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_num,
    output logic [3:0]  ducks_hit,
    output logic [7:0]  round_num,
    output logic [15:0] score,
    output logic        game_over
);
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        SPAWN     = 3'b001,
        FLY       = 3'b010,
        AWAY      = 3'b011,
        FALL      = 3'b100,
        ROUND_END = 3'b101,
        GAMEOVER  = 3'b110
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  fcnt_q, fcnt_d;
    logic [1:0]  shots_q, shots_d;
    logic [3:0]  duck_q, duck_d, hits_q, hits_d;
    logic [7:0]  round_q, round_d;
    logic [15:0] score_q, score_d;
    logic        shot_q, shot_d, new_round_q, new_round_d, game_over_q, game_over_d;
    logic        fc1_q, fc2_q, fe_q;
    logic        trg1_q, trg2_q, trg3_q, st1_q, st2_q;
    logic        tpulse, spulse, next_duck;
    logic [16:0] score_sum;

    assign tpulse    = trg2_q & ~trg3_q;
    assign spulse    = st1_q & ~st2_q;
    assign score_sum = {1'b0, score_q} + 17'(POINTS);

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        shots_d   = shots_q;
        duck_d    = duck_q;
        hits_d    = hits_q;
        round_d   = round_q;
        score_d   = score_q;
        shot_d    = shot_q;
        next_duck = 1'b0;
        // the duck block samples shot while fe is high; drop it right after
        if (fe_q && shot_q) shot_d = 1'b0;
        case (state_q)
            IDLE: if (spulse) begin
                state_d = SPAWN;
                duck_d  = '0;
                hits_d  = '0;
                score_d = '0;
                round_d = 8'd1;
            end
            SPAWN: if (fe_q) begin
                if (fcnt_q == 10'(SPAWN_FRAMES - 1)) state_d = FLY;
                else fcnt_d = fcnt_q + 10'd1;
            end
            FLY: begin
                if (tpulse && shots_q != 2'd0) begin
                    shots_d = shots_q - 2'd1;
                    if (hit) shot_d = 1'b1;
                end
                if (fe_q) fcnt_d = fcnt_q + 10'd1;
                if (bird_shot) state_d = FALL;
                else if (flew_away || (fe_q && fcnt_q == 10'(FLY_TIMEOUT - 1))) state_d = AWAY;
            end
            FALL: if (duck_ded_done) begin
                if (hits_q != 4'hF) hits_d = hits_q + 4'd1;
                score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                next_duck = 1'b1;
            end
            AWAY: if (fe_q) begin
                if (fcnt_q == 10'(AWAY_FRAMES - 1)) next_duck = 1'b1;
                else fcnt_d = fcnt_q + 10'd1;
            end
            ROUND_END: if (fe_q) begin
                if (fcnt_q == 10'(END_FRAMES - 1)) begin
                    if (hits_q >= 4'(PASS_HITS)) begin
                        round_d = (round_q == 8'd255) ? 8'd1 : round_q + 8'd1;
                        duck_d  = '0;
                        hits_d  = '0;
                        state_d = SPAWN;
                    end else begin
                        state_d = GAMEOVER;
                    end
                end else begin
                    fcnt_d = fcnt_q + 10'd1;
                end
            end
            GAMEOVER: if (spulse) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (next_duck) begin
            if (duck_q == 4'(DUCKS_PER_ROUND - 1)) state_d = ROUND_END;
            else begin
                duck_d  = duck_q + 4'd1;
                state_d = SPAWN;
            end
        end
        // every state starts its frame count afresh
        if (state_d != state_q) fcnt_d = '0;
        new_round_d = (state_d == SPAWN) && (state_q != SPAWN);
        if (new_round_d) shots_d = 2'(SHOTS_PER_DUCK);
        if (state_d != FLY) shot_d = 1'b0;
        game_over_d = (state_d == GAMEOVER);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            shots_q     <= 2'(SHOTS_PER_DUCK);
            duck_q      <= '0;
            hits_q      <= '0;
            round_q     <= 8'd1;
            score_q     <= '0;
            shot_q      <= 1'b0;
            new_round_q <= 1'b0;
            game_over_q <= 1'b0;
            fc1_q       <= 1'b0;
            fc2_q       <= 1'b0;
            fe_q        <= 1'b0;
            trg1_q      <= 1'b0;
            trg2_q      <= 1'b0;
            trg3_q      <= 1'b0;
            st1_q       <= 1'b0;
            st2_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            shots_q     <= shots_d;
            duck_q      <= duck_d;
            hits_q      <= hits_d;
            round_q     <= round_d;
            score_q     <= score_d;
            shot_q      <= shot_d;
            new_round_q <= new_round_d;
            game_over_q <= game_over_d;
            fc1_q       <= frame_clk;
            fc2_q       <= fc1_q;
            fe_q        <= fc1_q & ~fc2_q;
            trg1_q      <= trigger;
            trg2_q      <= trg1_q;
            trg3_q      <= trg2_q;
            st1_q       <= start;
            st2_q       <= st1_q;
        end
    end

    assign state      = state_q;
    assign new_round  = new_round_q;
    assign shot       = shot_q;
    assign shots_left = shots_q;
    assign duck_num   = duck_q;
    assign ducks_hit  = hits_q;
    assign round_num  = round_q;
    assign score      = score_q;
    assign game_over  = game_over_q;
endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: directed game flow with randomized duck outcomes,
// compared against a scoreboard of expected game counters.
module tb_duck_round_ctrl;
    logic        Clk = 1'b0, Reset_n = 1'b0;
    logic        frame_clk = 1'b0, start = 1'b0, trigger = 1'b0, hit = 1'b0;
    logic        bird_shot = 1'b0, flew_away = 1'b0, duck_ded_done = 1'b0;
    logic [2:0]  state;
    logic        new_round, shot, game_over;
    logic [1:0]  shots_left;
    logic [3:0]  duck_num, ducks_hit;
    logic [7:0]  round_num;
    logic [15:0] score;

    localparam int S_IDLE = 0, S_SPAWN = 1, S_FLY = 2, S_AWAY = 3, S_FALL = 4, S_END = 5, S_OVER = 6;

    duck_round_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
        .trigger(trigger), .hit(hit), .bird_shot(bird_shot), .flew_away(flew_away),
        .duck_ded_done(duck_ded_done), .state(state), .new_round(new_round), .shot(shot),
        .shots_left(shots_left), .duck_num(duck_num), .ducks_hit(ducks_hit),
        .round_num(round_num), .score(score), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    int nvec = 0, nerr = 0;
    int nr_cnt = 0, shot_cnt = 0;
    int exp_shots, exp_duck, exp_hits, exp_round, exp_score;
    bit exp_shot;

    always @(posedge Clk) begin
        if (new_round) nr_cnt <= nr_cnt + 1;
        if (shot) shot_cnt <= shot_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, expected finish within 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat (3) tick();
        frame_clk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
    endtask

    task automatic pull(input bit h);
        hit = h;
        trigger = 1'b1;
        repeat (4) tick();
        trigger = 1'b0;
        hit = 1'b0;
        repeat (3) tick();
    endtask

    // mode: 0 fly away, 1 bird_shot, 2 bird_shot with flew_away, 3 fly timeout
    task automatic run_duck(input int mode, input int pulls, input logic [3:0] hmask);
        int fly_fr, sc0;
        frame();
        chk("spawn_hold", state, S_SPAWN);
        frame();
        chk("spawn_to_fly", state, S_FLY);
        exp_shots = 3;
        exp_shot = 0;
        fly_fr = 0;
        chk("shots_full", shots_left, exp_shots);
        sc0 = shot_cnt;
        for (int i = 0; i < pulls; i++) begin
            pull(hmask[i]);
            if (exp_shots > 0) begin
                if (hmask[i]) exp_shot = 1;
                exp_shots--;
            end
            chk("shots_left", shots_left, exp_shots);
        end
        if (exp_shot) begin
            chk("shot_set", shot, 1);
            frame_clk = 1'b1;
            tick();
            chk("shot_pre_fe", shot, 1);
            tick();
            chk("shot_on_fe", shot, 1);
            tick();
            chk("shot_clr", shot, 0);
            frame_clk = 1'b0;
            repeat (3) tick();
            fly_fr++;
        end else begin
            chk("no_shot", shot_cnt - sc0, 0);
        end
        chk("still_fly", state, S_FLY);
        if (mode == 1 || mode == 2) begin
            bird_shot = 1'b1;
            flew_away = (mode == 2);
            tick();
            bird_shot = 1'b0;
            flew_away = 1'b0;
            chk("to_fall", state, S_FALL);
            chk("shot_off_fall", shot, 0);
            tick();
            duck_ded_done = 1'b1;
            tick();
            duck_ded_done = 1'b0;
            exp_hits++;
            exp_score += 500;
            chk("ducks_hit", ducks_hit, exp_hits);
            chk("score", score, exp_score);
        end else begin
            if (mode == 3) begin
                repeat (599 - fly_fr) frame();
                chk("fly_before_to", state, S_FLY);
                frame();
            end else begin
                flew_away = 1'b1;
                tick();
                flew_away = 1'b0;
            end
            chk("to_away", state, S_AWAY);
            repeat (59) frame();
            chk("away_hold", state, S_AWAY);
            frame();
        end
        if (exp_duck == 9) chk("to_round_end", state, S_END);
        else begin
            exp_duck++;
            chk("next_spawn", state, S_SPAWN);
            chk("duck_num", duck_num, exp_duck);
        end
    endtask

    task automatic run_round(input int target, input bit use_to);
        int hits_left, mode, pulls, nr0;
        bit first_hit, to_done;
        logic [3:0] hm;
        hits_left = target;
        first_hit = 1;
        to_done = 0;
        for (int d = 0; d < 10; d++) begin
            if (int'($urandom_range(1, 10 - d)) <= hits_left) begin
                mode = first_hit ? 2 : int'($urandom_range(1, 2));
                first_hit = 0;
                hits_left--;
            end else if (use_to && !to_done) begin
                mode = 3;
                to_done = 1;
            end else mode = 0;
            pulls = int'($urandom_range(0, 4));
            hm = 4'($urandom);
            if (d == 0) begin pulls = 4; hm = 4'b0000; end
            if (d == 1) begin pulls = 1; hm = 4'b0001; end
            run_duck(mode, pulls, hm);
        end
        repeat (119) frame();
        chk("end_hold", state, S_END);
        nr0 = nr_cnt;
        frame();
        if (target >= 6) begin
            exp_round++;
            exp_duck = 0;
            exp_hits = 0;
            chk("pass_spawn", state, S_SPAWN);
            chk("round_num", round_num, exp_round);
            chk("duck_rst", duck_num, 0);
            chk("hits_rst", ducks_hit, 0);
            chk("pass_new_round", nr_cnt - nr0, 1);
        end else begin
            chk("gameover", state, S_OVER);
            chk("game_over_o", game_over, 1);
            chk("round_hold", round_num, exp_round);
        end
    endtask

    initial begin
        int nr0;
        repeat (3) tick();
        chk("rst_state", state, S_IDLE);
        chk("rst_shots", shots_left, 3);
        chk("rst_duck", duck_num, 0);
        chk("rst_hits", ducks_hit, 0);
        chk("rst_round", round_num, 1);
        chk("rst_score", score, 0);
        chk("rst_shot", shot, 0);
        chk("rst_new_round", new_round, 0);
        chk("rst_game_over", game_over, 0);
        Reset_n = 1'b1;
        tick();
        exp_duck = 0; exp_hits = 0; exp_round = 1; exp_score = 0;

        nr0 = nr_cnt;
        press_start();
        chk("start_spawn", state, S_SPAWN);
        tick();
        chk("start_new_round", nr_cnt - nr0, 1);
        run_round(6, 0);
        run_round(5, 1);
        chk("over_score", score, exp_score);

        press_start();
        chk("over_to_idle", state, S_IDLE);
        chk("idle_score_held", score, exp_score);
        chk("idle_game_over", game_over, 0);
        press_start();
        chk("restart_spawn", state, S_SPAWN);
        chk("restart_score", score, 0);
        chk("restart_round", round_num, 1);
        frame();
        frame();
        chk("restart_fly", state, S_FLY);
        pull(1'b1);
        chk("pre_rst_shot", shot, 1);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_state", state, S_IDLE);
        chk("async_shot", shot, 0);
        chk("async_round", round_num, 1);
        chk("async_shots", shots_left, 3);
        tick();
        Reset_n = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
